// File: rtl/cache_fill_ctrl_if.sv
// Bus between the cache tag/data logic, the fill controller and the main memory port.
// The master side is the cache/memory environment; the slave side is the fill controller.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  localparam int OFF_W = $clog2(WORDS);

  // Request handshake: a request transfers on every rising edge where mem_req && mem_ready.
  // mem_req and memory_address hold steady until that edge; the memory may raise mem_ready
  // at any time. Responses return in order, one per cycle with memory_data_valid high.
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_ready;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [OFF_W-1:0]  word_num;
  logic              critical_word_wr;
  logic              fill_done;

  modport master (
    output miss_detected, miss_address, mem_ready, memory_data, memory_data_valid,
    input  fsm_busy, mem_req, memory_address, write_data_array, write_tag_array,
           word_num, critical_word_wr, fill_done
  );

  modport slave (
    input  miss_detected, miss_address, mem_ready, memory_data, memory_data_valid,
    output fsm_busy, mem_req, memory_address, write_data_array, write_tag_array,
           word_num, critical_word_wr, fill_done
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache-miss block-fill controller: issues WORDS pipelined word reads and writes responses in order.
// Define CRITICAL_WORD_FIRST_EN to start the fill at the missed word and wrap within the block.
module cache_fill_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS          = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int MAX_OUT        = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.slave  bus,
  output logic [1:0]        state_dbg
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int BW    = $clog2(BYTES_PER_WORD);
  localparam int BLK_W = OFF_W + BW;
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  miss_off;
  logic [OFF_W-1:0]  start;
  logic [OFF_W-1:0]  iss_idx;
  logic [OFF_W-1:0]  rcv_idx;
  logic              req;
  logic              issue;
  logic              accept;
  logic              last;
  logic              fill_done_r;
  logic              data_unused;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start = miss_off;
`else
  assign start = '0;
`endif

  // Word indices wrap modulo WORDS by truncation, so addresses never carry into the tag bits.
  assign iss_idx = start + iss_cnt[OFF_W-1:0];
  assign rcv_idx = start + rcv_cnt[OFF_W-1:0];

  assign req    = (state == FILL) && !iss_cnt[OFF_W]
                  && ((iss_cnt - rcv_cnt) < CNT_W'(MAX_OUT));
  assign issue  = req && bus.mem_ready;
  assign accept = (state == FILL) && bus.memory_data_valid && (rcv_cnt < iss_cnt);
  assign last   = accept && (rcv_cnt == CNT_W'(WORDS - 1));

  assign bus.mem_req          = req;
  assign bus.memory_address   = base | (ADDR_W'(iss_idx) << BW);
  assign bus.fsm_busy         = (state == IDLE) ? bus.miss_detected : 1'b1;
  assign bus.write_data_array = accept;
  assign bus.write_tag_array  = last;
  assign bus.word_num         = rcv_idx;
  assign bus.critical_word_wr = accept && (rcv_idx == miss_off);
  assign bus.fill_done        = fill_done_r;
  assign state_dbg            = state;

  // Read data goes straight into the data array, never through this block.
  assign data_unused = ^bus.memory_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iss_cnt     <= '0;
      rcv_cnt     <= '0;
      base        <= '0;
      miss_off    <= '0;
      fill_done_r <= 1'b0;
    end else begin
      fill_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            base     <= {bus.miss_address[ADDR_W-1:BLK_W], {BLK_W{1'b0}}};
            miss_off <= bus.miss_address[BLK_W-1:BW];
            iss_cnt  <= '0;
            rcv_cnt  <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (issue)  iss_cnt <= iss_cnt + CNT_W'(1);
          if (accept) rcv_cnt <= rcv_cnt + CNT_W'(1);
          if (last) begin
            state       <= DONE;
            fill_done_r <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: cycle-by-cycle model compare plus hand-computed fill orders.
module tb_cache_fill_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int BPW    = 2;
  localparam int MAXO   = 4;
  localparam int BLK    = WORDS * BPW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

  cache_fill_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS),
    .BYTES_PER_WORD(BPW), .MAX_OUT(MAXO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // ---------------- memory responder ----------------
  int   ready_mode = 0;   // 0: always ready, 1: toggling, 2: never ready
  bit   tog = 1'b0;
  bit   hold = 1'b0;
  bit   force_valid = 1'b0;
  int   pending = 0;
  bit   issue_evt = 1'b0;
  bit   acc_evt = 1'b0;
  bit   rst_s = 1'b0;
  logic [DATA_W-1:0] mem_word = '0;

  assign bus.mem_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? tog : 1'b0;
  assign bus.memory_data_valid = force_valid || (!hold && pending > 0);
  assign bus.memory_data = mem_word;

  always @(posedge clk) begin
    #1;
    if (rst_s) pending = 0;
    else pending = pending + int'(issue_evt) - int'(acc_evt);
    tog = ~tog;
    mem_word = 16'($urandom_range(0, 65535));
  end

  // ---------------- scoreboard logs ----------------
  logic [15:0] log_addr[$];
  logic [15:0] log_word[$];
  logic [15:0] log_crit[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_w[$];
  int tag_cyc, tag_word, done_cyc;
  bit done_seen;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_q(input string name, input logic [15:0] got[$], input logic [15:0] exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk(name, got[i], exp[i]);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_state = 0;   // 0 idle, 1 filling, 2 done
  int m_base = 0, m_off = 0, m_start = 0, m_iss = 0, m_rcv = 0;
  bit e_busy, e_req, e_acc, e_tag, e_crit, e_done;
  int e_word, e_addr;
  bit prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    rst_s = rst;
    e_busy = (m_state == 0) ? bus.miss_detected : 1'b1;
    e_req  = (m_state == 1) && (m_iss < WORDS) && (m_iss - m_rcv < MAXO);
    e_acc  = (m_state == 1) && bus.memory_data_valid && (m_rcv < m_iss);
    e_word = (m_start + m_rcv) % WORDS;
    e_addr = (m_base + ((m_start + m_iss) % WORDS) * BPW) & 16'hFFFF;
    e_tag  = e_acc && (m_rcv == WORDS - 1);
    e_crit = e_acc && (e_word == m_off);
    e_done = (m_state == 2);
    if (chk_en) begin
      chk("state", state_dbg, m_state);
      chk("fsm_busy", bus.fsm_busy, e_busy);
      chk("mem_req", bus.mem_req, e_req);
      if (e_req) chk("memory_address", bus.memory_address, e_addr);
      chk("write_data_array", bus.write_data_array, e_acc);
      if (e_acc) chk("word_num", bus.word_num, e_word);
      chk("write_tag_array", bus.write_tag_array, e_tag);
      chk("critical_word_wr", bus.critical_word_wr, e_crit);
      chk("fill_done", bus.fill_done, e_done);
      if (prev_stall) begin
        chk("stall_req_held", bus.mem_req, 1'b1);
        chk("stall_addr_held", bus.memory_address, prev_addr);
      end
    end
    prev_stall = bus.mem_req && !bus.mem_ready && !rst;
    prev_addr  = bus.memory_address;
    issue_evt  = bus.mem_req && bus.mem_ready;
    acc_evt    = bus.write_data_array;
    if (issue_evt) log_addr.push_back(bus.memory_address);
    if (acc_evt) log_word.push_back(16'(bus.word_num));
    if (bus.critical_word_wr) log_crit.push_back(16'(bus.word_num));
    if (bus.write_tag_array) begin
      tag_cyc  = cyc;
      tag_word = int'(bus.word_num);
    end
    if (bus.fill_done) begin
      done_cyc  = cyc;
      done_seen = 1'b1;
    end
    if (rst) begin
      m_state = 0; m_iss = 0; m_rcv = 0; m_base = 0; m_off = 0; m_start = 0;
    end else begin
      case (m_state)
        0: if (bus.miss_detected) begin
          m_base = int'(bus.miss_address) & ~(BLK - 1);
          m_off  = (int'(bus.miss_address) % BLK) / BPW;
`ifdef CRITICAL_WORD_FIRST_EN
          m_start = m_off;
`else
          m_start = 0;
`endif
          m_iss = 0; m_rcv = 0; m_state = 1;
        end
        1: begin
          if (e_req && bus.mem_ready) m_iss++;
          if (e_acc) m_rcv++;
          if (m_rcv == WORDS) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_word.delete(); log_crit.delete();
    done_seen = 1'b0; tag_cyc = -1; tag_word = -1; done_cyc = -1;
  endtask

  task automatic do_miss(input logic [15:0] a);
    bus.miss_detected = 1'b1;
    bus.miss_address  = a;
    tick();
    bus.miss_detected = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) at_neg();
    if (!done_seen) begin
      n_checks++; n_errors++;
      $display("FAIL fill_timeout: fill_done not seen within %0d cycles", budget);
    end
  endtask

  // Expected request/write order for a miss, from the block/offset arithmetic alone.
  task automatic fill_exp(input int miss);
    int b, off, st;
    b = miss & ~(BLK - 1);
    off = (miss % BLK) / BPW;
`ifdef CRITICAL_WORD_FIRST_EN
    st = off;
`else
    st = 0;
`endif
    exp_q.delete(); exp_w.delete();
    for (int k = 0; k < WORDS; k++) begin
      exp_q.push_back(16'(b + ((st + k) % WORDS) * BPW));
      exp_w.push_back(16'((st + k) % WORDS));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state_dbg, 0);
    chk({tag, "_busy"}, bus.fsm_busy, 0);
    chk({tag, "_req"}, bus.mem_req, 0);
    chk({tag, "_addr"}, bus.memory_address, 0);
    chk({tag, "_wda"}, bus.write_data_array, 0);
    chk({tag, "_wta"}, bus.write_tag_array, 0);
    chk({tag, "_word"}, bus.word_num, 0);
    chk({tag, "_crit"}, bus.critical_word_wr, 0);
    chk({tag, "_done"}, bus.fill_done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;
    clear_logs();
    tick();
    chk_en = 1'b1;
    at_neg();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    // Spurious valid while idle
    force_valid = 1'b1;
    tick(); tick();
    force_valid = 1'b0;
    tick();
    chk("idle_spurious_writes", log_word.size(), 0);

    // Basic fill at 0x1236, hand-computed order
    clear_logs();
    do_miss(16'h1236);
    wait_done(40);
`ifdef CRITICAL_WORD_FIRST_EN
    exp_q = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
    exp_w = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0, 16'd1, 16'd2};
    chk("basic_tag_word", tag_word, 2);
`else
    exp_q = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    exp_w = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    chk("basic_tag_word", tag_word, 7);
`endif
    chk_q("basic_addr", log_addr, exp_q);
    chk_q("basic_word", log_word, exp_w);
    chk("basic_crit_count", log_crit.size(), 1);
    if (log_crit.size() > 0) chk("basic_crit_word", log_crit[0], 3);
    chk("basic_done_after_tag", done_cyc, tag_cyc + 1);
    at_neg();
    chk("basic_busy_drops", bus.fsm_busy, 0);

    // Backpressure: responses withheld, outstanding limit caps issue
    tick();
    clear_logs();
    hold = 1'b1;
    do_miss(16'h2000);
    repeat (10) tick();
    at_neg();
    chk("bp_issued", log_addr.size(), MAXO);
    chk("bp_req_low", bus.mem_req, 0);
    chk("bp_no_writes", log_word.size(), 0);
    tick();
    hold = 1'b0;
    wait_done(60);
    fill_exp(16'h2000);
    chk_q("bp_addr", log_addr, exp_q);
    chk_q("bp_word", log_word, exp_w);

    // mem_ready toggling every cycle
    tick();
    clear_logs();
    ready_mode = 1;
    do_miss(16'h3008);
    wait_done(80);
    fill_exp(16'h3008);
    chk_q("toggle_addr", log_addr, exp_q);
    chk_q("toggle_word", log_word, exp_w);
    ready_mode = 0;

    // Spurious valid before first issue, plus a miss pulse during the fill
    tick();
    clear_logs();
    ready_mode = 2;
    do_miss(16'h1236);
    force_valid = 1'b1;
    tick();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h4000;
    tick();
    bus.miss_detected = 1'b0;
    force_valid = 1'b0;
    tick();
    at_neg();
    chk("prefill_spurious_writes", log_word.size(), 0);
    chk("prefill_no_issue", log_addr.size(), 0);
    tick();
    ready_mode = 0;
    wait_done(60);
    fill_exp(16'h1236);
    chk_q("ignore_miss_addr", log_addr, exp_q);
    chk_q("ignore_miss_word", log_word, exp_w);

    // Reset in the middle of a fill
    tick();
    clear_logs();
    do_miss(16'h5000);
    for (int i = 0; i < 40 && log_word.size() < 3; i++) at_neg();
    chk("midfill_reached_3", log_word.size() >= 3, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    chk_all_zero("midreset");
    tick();
    clear_logs();
    force_valid = 1'b1; tick();
    force_valid = 1'b0; tick();
    force_valid = 1'b1; tick();
    force_valid = 1'b0; tick();
    chk("late_valid_writes", log_word.size(), 0);
    clear_logs();
    do_miss(16'h0010);
    wait_done(40);
    fill_exp(16'h0010);
    chk_q("clean_addr", log_addr, exp_q);
    chk_q("clean_word", log_word, exp_w);
    at_neg();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
